// File: rtl/byte_unstriping_n.sv
// -----------------------------------------------------------------------------
// byte_unstriping_n
//
// Reassembles a byte stream that was striped across LANES parallel lanes.
// Each lane is buffered in its own DEPTH-entry FIFO so that lanes may arrive
// skewed. The FIFO heads are drained strictly round-robin (lane 0, 1, ...,
// LANES-1, 0, ...) into a registered valid/ready output port.
//
// Ports:
//   clk_f         in   single rising-edge clock
//   reset_L       in   asynchronous active-low reset
//   data_stripe   in   LANES*WIDTH, lane i at [i*WIDTH +: WIDTH]
//   valid_stripe  in   LANES, per-lane write strobe
//   lane_ready    out  LANES, lane FIFO not full (from registered count)
//   data_demux    out  WIDTH, reassembled byte (registered)
//   valid_demux   out  data_demux holds a valid byte (registered)
//   ready_demux   in   downstream accepts the byte this cycle
//   overflow      out  LANES, sticky per-lane drop flag
//   clear         in   synchronous flush of all state
// -----------------------------------------------------------------------------
module byte_unstriping_n #(
   parameter int LANES = 2,
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk_f,
   input  logic                   reset_L,
   input  logic [LANES*WIDTH-1:0] data_stripe,
   input  logic [LANES-1:0]       valid_stripe,
   output logic [LANES-1:0]       lane_ready,
   output logic [WIDTH-1:0]       data_demux,
   output logic                   valid_demux,
   input  logic                   ready_demux,
   output logic [LANES-1:0]       overflow,
   input  logic                   clear
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int RW = $clog2(LANES);

   // FIFO storage is never reset; occupancy is tracked solely by the counts.
   logic [WIDTH-1:0] mem_q [LANES][DEPTH];

   logic [CW-1:0]    count_q  [LANES];
   logic [CW-1:0]    count_d  [LANES];
   logic [PW-1:0]    wr_ptr_q [LANES];
   logic [PW-1:0]    wr_ptr_d [LANES];
   logic [PW-1:0]    rd_ptr_q [LANES];
   logic [PW-1:0]    rd_ptr_d [LANES];

   logic [RW-1:0]    rr_q, rr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [LANES-1:0] overflow_q, overflow_d;

   logic [LANES-1:0] full;
   logic [LANES-1:0] push;
   logic [LANES-1:0] pop;
   logic             load;
   logic             head_empty;
   logic             do_pop;

   // Output register may take a new byte when empty or being drained.
   assign load       = !valid_q || ready_demux;
   assign head_empty = (count_q[rr_q] == '0);
   assign do_pop     = load && !head_empty && !clear;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         // Fullness uses the registered count, so a same-cycle pop never
         // frees room for a push: a full lane drops and flags instead.
         assign full[gi]       = (count_q[gi] == CW'(DEPTH));
         assign push[gi]       = valid_stripe[gi] && !full[gi] && !clear;
         assign pop[gi]        = do_pop && (rr_q == RW'(gi));
         assign lane_ready[gi] = !full[gi];
      end
   endgenerate

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         count_d[i]  = count_q[i];
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         if (clear) begin
            count_d[i]  = '0;
            wr_ptr_d[i] = '0;
            rd_ptr_d[i] = '0;
         end else begin
            count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
         end
      end
   end

   always_comb begin
      rr_d       = rr_q;
      data_d     = data_q;
      valid_d    = valid_q;
      overflow_d = clear ? '0 : (overflow_q | (valid_stripe & full));
      if (clear) begin
         rr_d    = '0;
         valid_d = 1'b0;
      end else if (load) begin
         if (!head_empty) begin
            data_d  = mem_q[rr_q][rd_ptr_q[rr_q]];
            valid_d = 1'b1;
            rr_d    = (rr_q == RW'(LANES - 1)) ? '0 : rr_q + RW'(1);
         end else begin
            // Stall on the head lane rather than skipping it, keeping order.
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_f) begin
      for (int i = 0; i < LANES; i++) begin
         if (push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= data_stripe[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk_f or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < LANES; i++) begin
            count_q[i]  <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
         rr_q       <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         overflow_q <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            count_q[i]  <= count_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
         end
         rr_q       <= rr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign data_demux  = data_q;
   assign valid_demux = valid_q;
   assign overflow    = overflow_q;

endmodule
